i2s_decoder: RTL

I2S receiver, the counterpart of the I2S encoder. Takes an external I2S stream (BCLK, LRCLK, SDATA) and oversamples it in the i_mclk domain. Recovers one 16-bit stereo sample pair per frame and presents it with a single-cycle valid strobe, plus lock and framing-error status. Sits between an I2S source (codec/ADC or loopback from the encoder path) and the sample-consuming logic.

---
 rtl/i2s_decoder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/i2s_decoder.sv
// ---------------------------------------------------------------------------
// i2s_decoder
//
// I2S receiver. The external bit clock, word select and serial data are
// oversampled in the i_mclk domain. One 16-bit left/right sample pair is
// recovered per frame and presented with a single-cycle valid strobe.
// Lock and framing-error status are also reported.
//
// Ports
//   i_mclk    system clock; all logic runs on its rising edge
//   i_rst_x   asynchronous, active-low reset
//   i_bclk    external bit clock (asynchronous, <= i_mclk/4)
//   i_lrclk   external word select (0 = left, 1 = right)
//   i_sdata   external serial data, MSB first, one-bit I2S delay
//   o_data_l  last complete left sample
//   o_data_r  last complete right sample, paired with o_data_l
//   o_valid   one-cycle pulse when o_data_l/o_data_r update
//   o_err     one-cycle pulse on a short (malformed) half-frame
//   o_locked  high while receiving frames (LEFT or RIGHT state)
// ---------------------------------------------------------------------------
module i2s_decoder (
    input  logic        i_mclk,
    input  logic        i_rst_x,
    input  logic        i_bclk,
    input  logic        i_lrclk,
    input  logic        i_sdata,
    output logic [15:0] o_data_l,
    output logic [15:0] o_data_r,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_locked
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // Synchroniser chains, bit 0 = s1, bit 1 = s2, bit 2 = s3. All three
    // share the same depth so that data and word select stay aligned with
    // the detected bit-clock edge.
    logic [2:0]  bclk_sync;
    logic [2:0]  lr_sync;
    logic [2:0]  sd_sync;

    logic        lr_prev;
    logic [6:0]  bit_cnt;
    logic [6:0]  cnt_next;
    logic [15:0] shreg;
    logic [15:0] hold_l;

    logic        bclk_rise;
    logic        lr_s2;
    logic        sd_s2;
    logic        lr_chg;
    logic        well_formed;
    logic        shift_en;

    state_t      state_q;
    state_t      state_d;
    logic        latch_l;
    logic        emit;
    logic        frame_err;

    // ---- stage: input synchronisers -------------------------------------
    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            bclk_sync <= 3'b000;
            lr_sync   <= 3'b000;
            sd_sync   <= 3'b000;
        end else begin
            bclk_sync <= {bclk_sync[1:0], i_bclk};
            lr_sync   <= {lr_sync[1:0],   i_lrclk};
            sd_sync   <= {sd_sync[1:0],   i_sdata};
        end
    end

    assign bclk_rise   = bclk_sync[1] & ~bclk_sync[2];
    assign lr_s2       = lr_sync[1];
    assign sd_s2       = sd_sync[1];
    assign lr_chg      = bclk_rise & (lr_s2 != lr_prev);
    // Counter value before clearing: slots 1..16 carried data in this half.
    assign well_formed = (bit_cnt >= 7'd16);
    assign cnt_next    = (bit_cnt == 7'd127) ? 7'd127 : bit_cnt + 7'd1;
    // The LR-change rise is the delay slot, so its data bit is never taken.
    assign shift_en    = bclk_rise & ~lr_chg & (cnt_next <= 7'd16);

    // ---- stage: bit slot tracking and data capture ------------------------
    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            lr_prev <= 1'b0;
            bit_cnt <= 7'd0;
            shreg   <= 16'd0;
        end else if (bclk_rise) begin
            lr_prev <= lr_s2;
            bit_cnt <= lr_chg ? 7'd0 : cnt_next;
            if (shift_en) begin
                shreg <= {shreg[14:0], sd_s2};
            end
        end
    end

    // ---- frame state machine: state register ------------------------------
    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- frame state machine: next state ----------------------------------
    always_comb begin
        state_d   = state_q;
        latch_l   = 1'b0;
        emit      = 1'b0;
        frame_err = 1'b0;
        if (lr_chg) begin
            case (state_q)
                HUNT: begin
                    if (!lr_s2) begin
                        state_d = LEFT;
                    end
                end
                LEFT: begin
                    if (lr_s2) begin
                        if (well_formed) begin
                            latch_l = 1'b1;
                            state_d = RIGHT;
                        end else begin
                            frame_err = 1'b1;
                            state_d   = HUNT;
                        end
                    end
                end
                RIGHT: begin
                    if (!lr_s2) begin
                        if (well_formed) begin
                            emit    = 1'b1;
                            state_d = LEFT;
                        end else begin
                            frame_err = 1'b1;
                            state_d   = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // ---- frame state machine: outputs -------------------------------------
    always_comb begin
        o_locked = (state_q == LEFT) || (state_q == RIGHT);
    end

    // ---- stage: output registers ------------------------------------------
    always_ff @(posedge i_mclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            hold_l   <= 16'd0;
            o_data_l <= 16'd0;
            o_data_r <= 16'd0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_valid <= emit;
            o_err   <= frame_err;
            if (latch_l) begin
                hold_l <= shreg;
            end
            if (emit) begin
                o_data_l <= hold_l;
                o_data_r <= shreg;
            end
        end
    end

endmodule
